aes_block_sequencer: RTL and testbench
======================================

# aes_block_sequencer

Sequences the AES datapath between the AHB FIFO front end and the cipher core. Pulls 128-bit blocks from the receive FIFO, routes key blocks to the key register and data blocks through the core in the selected mode, and pushes results into the transmit FIFO. Drives the 8-bit `status` word read back over AHB at address 0x00.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT_CORE before a timeout error is raised; range 2..255.
- `HCLK` in 1: system clock; all logic is rising-edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `is_encrypt_pulse` in 1: one-cycle pulse that selects encrypt mode.
- `is_decrypt_pulse` in 1: one-cycle pulse that selects decrypt mode.
- `key_in` in 1: one-cycle pulse; the next receive-FIFO block is a key.
- `rcv_fifo_out` in 128: show-ahead head of the receive FIFO; valid while `rcv_fifo_empty` is 0.
- `rcv_fifo_empty` in 1: receive FIFO is empty.
- `rcv_deq` out 1: one-cycle pop of the receive FIFO.
- `tx_fifo_full` in 1: transmit FIFO is full.
- `tx_enq` out 1: one-cycle push to the transmit FIFO.
- `data_in` out 128: transmit FIFO write data; equals `result_reg`.
- `core_start` out 1: one-cycle start pulse to the AES core.
- `core_mode` out 1: 0 = encrypt, 1 = decrypt; held stable from START through WAIT_CORE.
- `core_key` out 128: `key_reg`.
- `core_block` out 128: `block_reg`.
- `core_done` in 1: one-cycle pulse; `core_result` is valid in the same cycle.
- `core_result` in 128: core output.
- `fix_error` in 1: clears the error state.
- `status` out 8: bit 0 = busy (state ≠ IDLE), bit 1 = mode, bit 2 = key_valid, bit 3 = tx_stall (in WRITE with `tx_fifo_full` high), bit 4 = error, bits 7:5 = completed-block count mod 8.

## Operation
- States: IDLE, LATCH, START, WAIT_CORE, WRITE, ERROR.
- Registers: `mode`, `key_pending`, `key_valid`, `key_reg`, `block_reg`, `result_reg`, `err`, `timeout_cnt[7:0]`, `blk_cnt[2:0]`.
- All outputs are Moore outputs decoded from the registered state.
- Mode selection:
  - An encrypt pulse alone sets `mode` = 0; a decrypt pulse alone sets `mode` = 1.
  - Both pulses in the same cycle are ignored and `mode` is unchanged.
  - Mode updates in any state; the core samples `mode` only when START is entered, so a change mid-block applies to the next block.
- `key_in` sets `key_pending` in any state. LATCH of a key block clears it, unless `key_in` is high in that same cycle, in which case it stays set.
- IDLE:
  - If `rcv_fifo_empty` = 0 → LATCH.
  - Otherwise stay in IDLE.
- LATCH (`rcv_deq` = 1 for exactly this cycle):
  - If `key_pending`: `key_reg` ← `rcv_fifo_out`, `key_valid` ← 1, → IDLE.
  - Else if `key_valid`: `block_reg` ← `rcv_fifo_out`, → START.
  - Else (data block with no key): the block is discarded, `err` ← 1, → ERROR.
- START: `core_start` = 1, `timeout_cnt` ← 0, → WAIT_CORE.
- WAIT_CORE:
  - On `core_done`: `result_reg` ← `core_result`, → WRITE.
  - Otherwise `timeout_cnt` increments. When it reaches TIMEOUT_CYCLES−1 without `core_done`: `err` ← 1, → ERROR.
  - `core_done` has priority over timeout in the same cycle.
- WRITE:
  - If `tx_fifo_full` = 0: `tx_enq` = 1, `blk_cnt` increments (wraps 7→0), → IDLE.
  - Otherwise hold in WRITE with `tx_stall` = 1. There is no timeout on the stall.
- ERROR:
  - No FIFO or core activity.
  - `fix_error` → `err` ← 0, → IDLE. `key_valid` is preserved.
- `fix_error` in any state other than ERROR has no effect.
- `core_done` outside WAIT_CORE is ignored.

## Timing
- Reset values:
  - State IDLE; `mode`, `key_pending`, `key_valid`, `err`, `timeout_cnt`, `blk_cnt` = 0.
  - `key_reg`, `block_reg`, `result_reg` = 0.
  - `rcv_deq`, `tx_enq`, `core_start` = 0; `status` = 0x00.
- Reset asserted mid-operation aborts immediately. An in-flight core result is lost, and the key must be reloaded.
- Data-path cycle sequence, with the block at the head in IDLE at cycle 0:
  - cycle 1: LATCH (`rcv_deq`)
  - cycle 2: START (`core_start`)
  - cycle 3 onward: WAIT_CORE
  - `core_done` at cycle d → cycle d+1: WRITE (`tx_enq` if not full)
  - cycle d+2: IDLE
- Throughput: one block per 3 + core-latency cycles, plus one IDLE cycle between blocks.
- A key block takes 2 cycles (IDLE→LATCH→IDLE).
- `status` reflects registered state with no additional delay.

## Test plan
- Reset only → `status` = 0x00, `rcv_deq`/`tx_enq`/`core_start` = 0, state IDLE.
- `key_in` pulse, push key "ZXCVBNMASDFGHJKL", then data "1234567890123456"; core model returns done 10 cycles after start with result = block XOR key → one `rcv_deq` each for key and data; `core_start` 2 cycles after the data block reaches the head; `tx_enq` one cycle after `core_done` with `data_in` = XOR value; `status` = 0x24 (key_valid, count 1).
- Decrypt pulse then data block → `core_mode` = 1 during WAIT_CORE and `status[1]` = 1. Encrypt and decrypt pulses in the same cycle → `mode` unchanged.
- Data pushed with no key loaded → block dequeued, `status[4]` = 1, no `core_start`. `fix_error` pulse → `status` = 0x00, IDLE.
- Core never asserts done with TIMEOUT_CYCLES = 8 → ERROR entered 8 cycles after START, `status` = 0x15 (busy, key_valid, error). `fix_error` returns to IDLE with `key_valid` still 1.
- `tx_fifo_full` held high for 5 cycles at WRITE → `status[3]` = 1 for those cycles, no `tx_enq`. `tx_enq` in the first cycle after full drops. Eight blocks processed → `blk_cnt` wraps to 0.

Source files
------------

// File: rtl/aes_block_sequencer.sv
// AES block sequencer: moves 128-bit blocks from the receive FIFO into the key
// register or through the cipher core, and pushes results to the transmit FIFO.
module aes_block_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         is_encrypt_pulse,
  input  logic         is_decrypt_pulse,
  input  logic         key_in,
  input  logic [127:0] rcv_fifo_out,
  input  logic         rcv_fifo_empty,
  output logic         rcv_deq,
  input  logic         tx_fifo_full,
  output logic         tx_enq,
  output logic [127:0] data_in,
  output logic         core_start,
  output logic         core_mode,
  output logic [127:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_done,
  input  logic [127:0] core_result,
  input  logic         fix_error,
  output logic [7:0]   status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_WAIT_CORE,
    S_WRITE,
    S_ERROR
  } state_t;

  // Last WAIT_CORE count value before the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 2);

  state_t       state;
  logic         mode;
  logic         core_mode_r;
  logic         key_pending;
  logic         key_valid;
  logic [127:0] key_reg;
  logic [127:0] block_reg;
  logic [127:0] result_reg;
  logic         err;
  logic [7:0]   timeout_cnt;
  logic [2:0]   blk_cnt;

  // Sequencer state machine with mode/key bookkeeping.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      mode        <= 1'b0;
      core_mode_r <= 1'b0;
      key_pending <= 1'b0;
      key_valid   <= 1'b0;
      key_reg     <= '0;
      block_reg   <= '0;
      result_reg  <= '0;
      err         <= 1'b0;
      timeout_cnt <= '0;
      blk_cnt     <= '0;
    end else begin
      if (is_encrypt_pulse ^ is_decrypt_pulse) mode <= is_decrypt_pulse;
      if (key_in) key_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!rcv_fifo_empty) state <= S_LATCH;
        end
        S_LATCH: begin
          if (key_pending) begin
            key_reg     <= rcv_fifo_out;
            key_valid   <= 1'b1;
            // A key_in arriving in the same cycle marks the following block as a key.
            key_pending <= key_in;
            state       <= S_IDLE;
          end else if (key_valid) begin
            block_reg   <= rcv_fifo_out;
            // Mode is captured on entry to START and held for the whole block.
            core_mode_r <= mode;
            state       <= S_START;
          end else begin
            err   <= 1'b1;
            state <= S_ERROR;
          end
        end
        S_START: begin
          timeout_cnt <= '0;
          state       <= S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          if (core_done) begin
            result_reg <= core_result;
            state      <= S_WRITE;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
            if (timeout_cnt == TO_LAST) begin
              err   <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        S_WRITE: begin
          if (!tx_fifo_full) begin
            blk_cnt <= blk_cnt + 3'd1;
            state   <= S_IDLE;
          end
        end
        S_ERROR: begin
          if (fix_error) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    rcv_deq    = (state == S_LATCH);
    core_start = (state == S_START);
    tx_enq     = (state == S_WRITE) && !tx_fifo_full;
    status     = {blk_cnt, err, (state == S_WRITE) && tx_fifo_full,
                  key_valid, mode, (state != S_IDLE)};
  end

  assign data_in    = result_reg;
  assign core_mode  = core_mode_r;
  assign core_key   = key_reg;
  assign core_block = block_reg;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Randomized scoreboard bench for aes_block_sequencer with a behavioural
// FIFO/core environment and a transaction-level reference model.
module tb_aes_block_sequencer;

  logic         tb_HCLK = 1'b0;
  logic         HRESETn;
  logic         is_encrypt_pulse, is_decrypt_pulse, key_in, fix_error;
  logic [127:0] rcv_fifo_out;
  logic         rcv_fifo_empty;
  logic         rcv_deq, tx_enq, core_start, core_mode;
  logic         tx_fifo_full;
  logic [127:0] data_in, core_key, core_block, core_result;
  logic         core_done;
  logic [7:0]   status;

  always #5 tb_HCLK = ~tb_HCLK;

  aes_block_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK(tb_HCLK), .HRESETn(HRESETn),
    .is_encrypt_pulse(is_encrypt_pulse), .is_decrypt_pulse(is_decrypt_pulse),
    .key_in(key_in), .rcv_fifo_out(rcv_fifo_out), .rcv_fifo_empty(rcv_fifo_empty),
    .rcv_deq(rcv_deq), .tx_fifo_full(tx_fifo_full), .tx_enq(tx_enq),
    .data_in(data_in), .core_start(core_start), .core_mode(core_mode),
    .core_key(core_key), .core_block(core_block), .core_done(core_done),
    .core_result(core_result), .fix_error(fix_error), .status(status)
  );

  int unsigned n_chk = 0, n_pass = 0;

  // environment state
  logic [127:0] push_q[$];
  logic [127:0] rcv_q[$];
  int unsigned  pops_req = 0, pops_done = 0;
  logic         rand_full = 1'b0, full_force = 1'b0, rand_bit = 1'b0;
  int unsigned  core_lat = 3;
  logic         core_busy = 1'b0;

  assign tx_fifo_full = rand_full ? rand_bit : full_force;

  // scoreboard queues
  logic [127:0] tx_q[$];
  logic         start_q[$];

  // reference model
  logic [127:0] m_key = '0;
  logic         m_kv = 1'b0, m_mode = 1'b0;
  logic [2:0]   m_cnt = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  function automatic logic [7:0] idle_status();
    return {m_cnt, 2'b00, m_kv, m_mode, 1'b0};
  endfunction

  // Receive FIFO model and random transmit back-pressure.
  initial forever begin
    @(posedge tb_HCLK); #1;
    while (pops_done != pops_req) begin
      if (rcv_q.size() > 0) void'(rcv_q.pop_front());
      pops_done++;
    end
    while (push_q.size() > 0) rcv_q.push_back(push_q.pop_front());
    rcv_fifo_empty = (rcv_q.size() == 0);
    rcv_fifo_out   = rcv_fifo_empty ? '0 : rcv_q[0];
    rand_bit       = ($urandom_range(0, 3) == 0);
  end

  // Cipher core model: result = block XOR key after core_lat cycles (0 = never).
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge tb_HCLK);
      if (HRESETn && core_start && core_lat > 0) begin
        logic [127:0] r;
        int unsigned  l;
        r = core_block ^ core_key;
        l = core_lat;
        core_busy = 1'b1;
        repeat (l) @(posedge tb_HCLK);
        #1 core_done = 1'b1; core_result = r;
        @(posedge tb_HCLK);
        #1 core_done = 1'b0; core_busy = 1'b0;
      end
    end
  end

  // Monitor: compares DUT transactions against the scoreboard queues.
  initial begin
    logic prev_deq, prev_done, in_blk, blk_mode;
    prev_deq = 0; prev_done = 0; in_blk = 0; blk_mode = 0;
    forever begin
      @(negedge tb_HCLK);
      if (!HRESETn) begin
        prev_deq = 0; prev_done = 0; in_blk = 0;
      end else begin
        if (core_start) begin
          check("start_after_deq", 128'(prev_deq), 128'(1));
          if (start_q.size() == 0) fail_now("unexpected_core_start");
          else check("core_mode_at_start", 128'(core_mode), 128'(start_q.pop_front()));
          blk_mode = core_mode;
          in_blk   = 1;
        end
        if (core_done && in_blk) check("core_mode_hold", 128'(core_mode), 128'(blk_mode));
        if (prev_done) check("write_after_done", 128'(tx_enq | status[3]), 128'(1));
        if (status[3]) check("stall_no_enq", 128'({tx_fifo_full, tx_enq}), 128'(2'b10));
        prev_done = core_done && in_blk;
        if (tx_enq) begin
          if (tx_q.size() == 0) fail_now("unexpected_tx_enq");
          else check("tx_data", data_in, tx_q.pop_front());
          in_blk = 0;
        end
        if (status[4]) in_blk = 0;
        if (rcv_deq) pops_req++;
        prev_deq = rcv_deq;
      end
    end
  end

  task automatic step();
    @(posedge tb_HCLK); #1;
  endtask

  task automatic pulse(input logic k, input logic e, input logic d, input logic f);
    key_in = k; is_encrypt_pulse = e; is_decrypt_pulse = d; fix_error = f;
    step();
    key_in = 0; is_encrypt_pulse = 0; is_decrypt_pulse = 0; fix_error = 0;
  endtask

  // mp: 0 none, 1 encrypt, 2 decrypt, 3 both (ignored)
  task automatic set_mode(input int unsigned mp);
    case (mp)
      1: begin pulse(0, 1, 0, 0); m_mode = 1'b0; end
      2: begin pulse(0, 0, 1, 0); m_mode = 1'b1; end
      3: pulse(0, 1, 1, 0);
      default: ;
    endcase
  endtask

  task automatic check_idle(input string nm);
    @(negedge tb_HCLK);
    check(nm, 128'(status), 128'(idle_status()));
    step();
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge tb_HCLK);
      if (push_q.size() == 0 && rcv_q.size() == 0 && pops_req == pops_done &&
          !status[0] && !core_busy) ok = 1;
    end
    if (!ok) fail_now(nm);
    step();
  endtask

  task automatic wait_start(input string nm);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge tb_HCLK);
      if (core_start) ok = 1;
    end
    if (!ok) fail_now(nm);
    step();
  endtask

  task automatic wait_err(input string nm);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge tb_HCLK);
      if (status[4]) ok = 1;
    end
    if (!ok) fail_now(nm);
    step();
  endtask

  task automatic do_key(input logic [127:0] k);
    pulse(1, 0, 0, 0);
    push_q.push_back(k);
    m_key = k;
    m_kv  = 1'b1;
    wait_idle("key_load_done");
    check_idle("status_after_key");
  endtask

  task automatic do_data(input logic [127:0] blk, input int unsigned lat,
                         input int unsigned mp, input bit mid);
    set_mode(mp);
    core_lat = lat;
    push_q.push_back(blk);
    if (m_kv) begin
      start_q.push_back(m_mode);
      tx_q.push_back(blk ^ m_key);
      m_cnt = m_cnt + 3'd1;
      if (mid) begin
        wait_start("mid_start");
        set_mode($urandom_range(1, 3));
      end
      wait_idle("data_done");
      check_idle("status_after_data");
    end else begin
      wait_err("no_key_error");
      @(negedge tb_HCLK);
      check("status_no_key", 128'(status), 128'({m_cnt, 2'b10, 1'b0, m_mode, 1'b1}));
      step();
      pulse(0, 0, 0, 1);
      check_idle("status_after_fix");
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESETn = 0; key_in = 0; is_encrypt_pulse = 0; is_decrypt_pulse = 0; fix_error = 0;
    rcv_fifo_empty = 1; rcv_fifo_out = '0;
    repeat (3) step();
    @(negedge tb_HCLK);
    check("reset_status", 128'(status), 128'(0));
    check("reset_strobes", 128'({rcv_deq, tx_enq, core_start}), 128'(0));
    step();
    HRESETn = 1;
    check_idle("status_after_reset");

    // data with no key loaded
    do_data(rand128(), 3, 0, 0);

    // key then data, longest latency that still beats the timeout
    do_key("ZXCVBNMASDFGHJKL");
    do_data("1234567890123456", 7, 0, 0);
    @(negedge tb_HCLK);
    check("status_0x24", 128'(status), 128'(8'h24));
    step();

    // decrypt block, then both pulses together leave mode alone
    do_data(rand128(), 4, 2, 0);
    set_mode(3);
    check_idle("both_pulses_ignored");

    // core never finishes: timeout 8 cycles after START
    set_mode(1);
    core_lat = 0;
    start_q.push_back(m_mode);
    push_q.push_back(rand128());
    wait_start("timeout_start");
    for (int k = 1; k <= 8; k++) begin
      @(negedge tb_HCLK);
      if (k == 7) check("no_error_before_timeout", 128'(status[4]), 128'(0));
      if (k == 8) check("status_timeout", 128'(status), 128'({m_cnt, 2'b10, m_kv, m_mode, 1'b1}));
    end
    step();
    pulse(0, 0, 0, 1);
    check_idle("status_after_timeout_fix");

    // transmit FIFO full for 5 cycles at WRITE
    full_force = 1;
    begin
      logic [127:0] b;
      bit ok;
      b = rand128();
      core_lat = 3;
      start_q.push_back(m_mode);
      tx_q.push_back(b ^ m_key);
      m_cnt = m_cnt + 3'd1;
      push_q.push_back(b);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge tb_HCLK);
        if (status[3]) ok = 1;
      end
      if (!ok) fail_now("stall_seen");
      for (int i = 0; i < 4; i++) begin
        @(negedge tb_HCLK);
        check("stall_held", 128'({status[3], tx_enq}), 128'(2'b10));
      end
      @(posedge tb_HCLK); #1;
      full_force = 0;
      @(negedge tb_HCLK);
      check("enq_after_full_drops", 128'(tx_enq), 128'(1));
      step();
      wait_idle("stall_done");
      check_idle("status_after_stall");
    end

    // randomized traffic with back-pressure; block count wraps several times
    rand_full = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) do_key(rand128());
      else do_data(rand128(), $urandom_range(1, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    rand_full = 0;

    // reset in the middle of a block discards it and the key
    set_mode(2);
    core_lat = 5;
    start_q.push_back(m_mode);
    push_q.push_back(rand128());
    wait_start("reset_abort_start");
    step();
    HRESETn = 0;
    @(negedge tb_HCLK);
    check("mid_reset_status", 128'(status), 128'(0));
    check("mid_reset_strobes", 128'({rcv_deq, tx_enq, core_start}), 128'(0));
    step();
    HRESETn = 1;
    m_kv = 0; m_mode = 0; m_cnt = '0;
    tx_q.delete();
    start_q.delete();
    repeat (8) step();
    check_idle("status_after_abort");
    do_data(rand128(), 3, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
